// File: rtl/dmem_access_arbiter_if.sv
// Bundle of the two requester ports and the datamem control lines.
// slave = arbiter side; master = requesters plus the memory model.
interface dmem_access_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          rw0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          done0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          rw1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          done1;
  logic [DW-1:0] rdata1;

  logic [AW-1:0] mem_ina;
  logic [DW-1:0] mem_inb;
  logic          mem_enable;
  logic          mem_readwrite;
  logic [DW-1:0] mem_dataout;
  logic          busy;

  modport slave (
    input  req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, mem_dataout,
    output gnt0, done0, rdata0, gnt1, done1, rdata1,
           mem_ina, mem_inb, mem_enable, mem_readwrite, busy
  );

  modport master (
    output req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, mem_dataout,
    input  gnt0, done0, rdata0, gnt1, done1, rdata1,
           mem_ina, mem_inb, mem_enable, mem_readwrite, busy
  );
endinterface

// File: rtl/dmem_access_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between two
// requesters; each access holds mem_enable for MEM_LATENCY cycles.
module dmem_access_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  dmem_access_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          last_grant, last_grant_nxt;
  logic          cur, cur_nxt;
  logic          pick1;
  logic [AW-1:0] ina, ina_nxt;
  logic [DW-1:0] inb, inb_nxt;
  logic          rw, rw_nxt;
  logic          en, en_nxt;
  logic          gnt0, gnt0_nxt, gnt1, gnt1_nxt;
  logic          done0, done0_nxt, done1, done1_nxt;
  logic [DW-1:0] rdata0, rdata0_nxt, rdata1, rdata1_nxt;
  logic          busy, busy_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Every output is a register loaded from its _nxt value, so the comb
  // block below computes the value each output takes in the next state.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    cur_nxt        = cur;
    ina_nxt        = ina;
    inb_nxt        = inb;
    rw_nxt         = rw;
    en_nxt         = 1'b0;
    gnt0_nxt       = 1'b0;
    gnt1_nxt       = 1'b0;
    done0_nxt      = 1'b0;
    done1_nxt      = 1'b0;
    rdata0_nxt     = rdata0;
    rdata1_nxt     = rdata1;
    // Port 1 wins when alone, or on a tie when port 0 was served last.
    pick1          = bus.req1 && (!bus.req0 || !last_grant);

    unique case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_nxt = ACCESS;
          cnt_nxt   = CNT_INIT;
          cur_nxt   = pick1;
          en_nxt    = 1'b1;
          ina_nxt   = pick1 ? bus.addr1  : bus.addr0;
          inb_nxt   = pick1 ? bus.wdata1 : bus.wdata0;
          rw_nxt    = pick1 ? bus.rw1    : bus.rw0;
          gnt0_nxt  = !pick1;
          gnt1_nxt  = pick1;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_nxt      = RESP;
          last_grant_nxt = cur;
          done0_nxt      = !cur;
          done1_nxt      = cur;
          if (!rw) begin
            if (cur) rdata1_nxt = bus.mem_dataout;
            else     rdata0_nxt = bus.mem_dataout;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
          en_nxt  = 1'b1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        ina_nxt   = '0;
        inb_nxt   = '0;
        rw_nxt    = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      cur        <= 1'b0;
      ina        <= '0;
      inb        <= '0;
      rw         <= 1'b0;
      en         <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      busy       <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      cur        <= cur_nxt;
      ina        <= ina_nxt;
      inb        <= inb_nxt;
      rw         <= rw_nxt;
      en         <= en_nxt;
      gnt0       <= gnt0_nxt;
      gnt1       <= gnt1_nxt;
      done0      <= done0_nxt;
      done1      <= done1_nxt;
      rdata0     <= rdata0_nxt;
      rdata1     <= rdata1_nxt;
      busy       <= busy_nxt;
    end
  end

  assign bus.gnt0          = gnt0;
  assign bus.gnt1          = gnt1;
  assign bus.done0         = done0;
  assign bus.done1         = done1;
  assign bus.rdata0        = rdata0;
  assign bus.rdata1        = rdata1;
  assign bus.mem_ina       = ina;
  assign bus.mem_inb       = inb;
  assign bus.mem_enable    = en;
  assign bus.mem_readwrite = rw;
  assign bus.busy          = busy;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Bench for dmem_access_arbiter: a MEM_LATENCY=2 instance with a scoreboard
// on its completions, plus a MEM_LATENCY=1 instance for the short-access case.
module tb_dmem_access_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic load;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dmem_access_arbiter_if #(.AW(32), .DW(32)) bus  ();
  dmem_access_arbiter_if #(.AW(32), .DW(32)) bus1 ();

  dmem_access_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dmem_access_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Memory models: combinational read, write on the clock edge while enabled.
  logic [31:0] mem  [16];
  logic [31:0] mem1 [16];
  logic [31:0] ref_mem [16];

  assign bus.mem_dataout  = mem[bus.mem_ina[3:0]];
  assign bus1.mem_dataout = mem1[bus1.mem_ina[3:0]];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) begin
        mem[i]  <= 32'h1000_0000 + 32'(i);
        mem1[i] <= 32'h2000_0000 + 32'(i);
      end
      mem[3]  <= 32'hDEADBEEF;
      mem1[0] <= 32'hCAFE0001;
    end else begin
      if (bus.mem_enable && bus.mem_readwrite)   mem[bus.mem_ina[3:0]]   <= bus.mem_inb;
      if (bus1.mem_enable && bus1.mem_readwrite) mem1[bus1.mem_ina[3:0]] <= bus1.mem_inb;
    end
  end

  // Scoreboard of expected completions on the main instance, in order.
  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic [31:0] other;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] exp_rdata [2];

  task automatic push_exp(input int port, input bit rw, input int addr, input logic [31:0] wdata);
    exp_t e;
    if (rw) ref_mem[addr & 15] = wdata;
    else    exp_rdata[port]    = ref_mem[addr & 15];
    e.port  = port;
    e.rdata = exp_rdata[port];
    e.other = exp_rdata[1 - port];
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t        e;
    int          aport;
    logic [31:0] ar, ao;
    if (!rst && !load) begin
      checks++;
      if (bus.gnt0 && bus.gnt1) begin
        failures++;
        $display("FAIL gnt_exclusive gnt0=%b gnt1=%b required at most one", bus.gnt0, bus.gnt1);
      end
      checks++;
      if (bus.done0 && bus.done1) begin
        failures++;
        $display("FAIL done_exclusive done0=%b done1=%b required at most one", bus.done0, bus.done1);
      end
      if (bus.done0 || bus.done1) begin
        aport = bus.done1 ? 1 : 0;
        ar    = aport ? bus.rdata1 : bus.rdata0;
        ao    = aport ? bus.rdata0 : bus.rdata1;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done port=%0d with nothing outstanding", aport);
        end else begin
          e = sb.pop_front();
          if (aport != e.port || ar !== e.rdata || ao !== e.other) begin
            failures++;
            $display("FAIL sb_done port=%0d rdata=%h other=%h required port=%0d rdata=%h other=%h",
                     aport, ar, ao, e.port, e.rdata, e.other);
          end
        end
      end
    end
  end

  task automatic set_req(input int port, input bit v, input bit rw, input int addr, input logic [31:0] wdata);
    if (port == 0) begin
      bus.req0 = v; bus.rw0 = rw; bus.addr0 = 32'(addr); bus.wdata0 = wdata;
    end else begin
      bus.req1 = v; bus.rw1 = rw; bus.addr1 = 32'(addr); bus.wdata1 = wdata;
    end
  endtask

  // Waits at negedges for a grant on the port; ok=0 if none within the budget.
  task automatic wait_gnt(input int port, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk);
      ok = (port == 0) ? bus.gnt0 : bus.gnt1;
    end
  endtask

  // From the grant cycle, counts enable cycles and control mismatches until done.
  task automatic observe(input int port, input bit rw, input int addr, input logic [31:0] wdata,
                         output int en_cnt, output int bad, output bit done_ok);
    en_cnt  = 0;
    bad     = 0;
    done_ok = 1'b0;
    for (int n = 0; n < 30 && !done_ok; n++) begin
      if (bus.mem_enable) begin
        en_cnt++;
        if (bus.mem_ina !== 32'(addr) || bus.mem_readwrite !== rw || (rw && bus.mem_inb !== wdata))
          bad++;
      end
      done_ok = (port == 0) ? bus.done0 : bus.done1;
      if (!done_ok) @(negedge clk);
    end
  endtask

  task automatic wait_sb_empty(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain outstanding=%0d required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic single_access(input int port, input bit rw, input int addr, input logic [31:0] wdata,
                               output int en_cnt, output int bad, output bit ok);
    bit g;
    @(posedge clk); #1;
    set_req(port, 1'b1, rw, addr, wdata);
    push_exp(port, rw, addr, wdata);
    wait_gnt(port, g);
    set_req(port, 1'b0, 1'b0, 0, 32'h0);
    observe(port, rw, addr, wdata, en_cnt, bad, ok);
    ok = ok && g;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    load = 1'b1;
    set_req(0, 1'b0, 1'b0, 0, 32'h0);
    set_req(1, 1'b0, 1'b0, 0, 32'h0);
    bus1.req0 = 1'b0; bus1.rw0 = 1'b0; bus1.addr0 = '0; bus1.wdata0 = '0;
    bus1.req1 = 1'b0; bus1.rw1 = 1'b0; bus1.addr1 = '0; bus1.wdata1 = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
    ref_mem[3]   = 32'hDEADBEEF;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_enable, bus.mem_readwrite, bus.busy} !== 7'b0 ||
        bus.rdata0 !== '0 || bus.rdata1 !== '0 || bus.mem_ina !== '0 || bus.mem_inb !== '0) begin
      failures++;
      $display("FAIL reset_outputs ctl=%b rdata0=%h rdata1=%h ina=%h required all zero",
               {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_enable, bus.mem_readwrite, bus.busy},
               bus.rdata0, bus.rdata1, bus.mem_ina);
    end
    checks++;
    if ({bus1.gnt0, bus1.done0, bus1.mem_enable, bus1.busy} !== 4'b0) begin
      failures++;
      $display("FAIL reset_outputs_lat1 ctl=%b required 0000", {bus1.gnt0, bus1.done0, bus1.mem_enable, bus1.busy});
    end
    rst  = 1'b0;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 3, 32'h0);
    push_exp(0, 1'b0, 3, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL read_cycle_t gnt0=%b busy=%b required 0 0", bus.gnt0, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.mem_enable !== 1'b1 || bus.mem_ina !== 32'd3 || bus.mem_readwrite !== 1'b0) begin
      failures++;
      $display("FAIL read_t1 gnt0=%b en=%b ina=%h rw=%b required 1 1 3 0",
               bus.gnt0, bus.mem_enable, bus.mem_ina, bus.mem_readwrite);
    end
    set_req(0, 1'b0, 1'b0, 0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b0 || bus.mem_enable !== 1'b1 || bus.done0 !== 1'b0) begin
      failures++;
      $display("FAIL read_t2 gnt0=%b en=%b done0=%b required 0 1 0", bus.gnt0, bus.mem_enable, bus.done0);
    end
    @(negedge clk);
    checks++;
    if (bus.done0 !== 1'b1 || bus.rdata0 !== 32'hDEADBEEF || bus.mem_enable !== 1'b0 ||
        bus.done1 !== 1'b0 || bus.rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL read_t3 done0=%b rdata0=%h en=%b done1=%b rdata1=%h required 1 deadbeef 0 0 0",
               bus.done0, bus.rdata0, bus.mem_enable, bus.done1, bus.rdata1);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done0 !== 1'b0 || bus.rdata0 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL read_after busy=%b done0=%b rdata0=%h required 0 0 deadbeef", bus.busy, bus.done0, bus.rdata0);
    end
  endtask

  task automatic test_write_read();
    int en_cnt, bad;
    bit ok;
    single_access(1, 1'b1, 5, 32'h12345678, en_cnt, bad, ok);
    checks++;
    if (!ok || en_cnt != 2 || bad != 0) begin
      failures++;
      $display("FAIL write_port1 done=%b en_cycles=%0d bad=%0d required 1 2 0", ok, en_cnt, bad);
    end
    single_access(0, 1'b0, 5, 32'h0, en_cnt, bad, ok);
    checks++;
    if (!ok || en_cnt != 2 || bad != 0 || bus.rdata0 !== 32'h12345678 || bus.rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL read_back done=%b en_cycles=%0d bad=%0d rdata0=%h rdata1=%h required 1 2 0 12345678 0",
               ok, en_cnt, bad, bus.rdata0, bus.rdata1);
    end
  endtask

  task automatic test_contention();
    int en_cnt, bad, ngr, idle, gaps_bad;
    int order [4];
    bit ok;
    // Serve port 1 last so the first contended grant belongs to port 0.
    single_access(1, 1'b0, 5, 32'h0, en_cnt, bad, ok);
    checks++;
    if (!ok || bus.rdata1 !== 32'h12345678) begin
      failures++;
      $display("FAIL prep_read1 done=%b rdata1=%h required 1 12345678", ok, bus.rdata1);
    end
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 3, 32'h0);
    set_req(1, 1'b1, 1'b0, 5, 32'h0);
    for (int i = 0; i < 4; i++) push_exp(i % 2, 1'b0, (i % 2) ? 5 : 3, 32'h0);
    ngr = 0; idle = 0; gaps_bad = 0;
    for (int n = 0; n < 80 && ngr < 4; n++) begin
      @(negedge clk);
      if (!bus.busy) idle++;
      else begin
        if (idle > 0 && ngr > 0 && idle != 1) gaps_bad++;
        idle = 0;
      end
      if (bus.gnt0 || bus.gnt1) begin
        order[ngr] = bus.gnt1 ? 1 : 0;
        ngr++;
        if (ngr == 4) begin
          set_req(0, 1'b0, 1'b0, 0, 32'h0);
          set_req(1, 1'b0, 1'b0, 0, 32'h0);
        end
      end
    end
    checks++;
    if (ngr != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
      failures++;
      $display("FAIL contention_order grants=%0d order=%0d%0d%0d%0d required 4 0101",
               ngr, order[0], order[1], order[2], order[3]);
    end
    checks++;
    if (gaps_bad != 0) begin
      failures++;
      $display("FAIL contention_idle_gap bad_gaps=%0d required 0", gaps_bad);
    end
    wait_sb_empty("contention");
    @(negedge clk);
  endtask

  task automatic test_late_req();
    bit g;
    int done0_n, gnt1_n, n;
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 3, 32'h0);
    push_exp(0, 1'b0, 3, 32'h0);
    wait_gnt(0, g);
    set_req(0, 1'b0, 1'b0, 0, 32'h0);
    set_req(1, 1'b1, 1'b0, 5, 32'h0);
    push_exp(1, 1'b0, 5, 32'h0);
    done0_n = -1; gnt1_n = -1; n = 0;
    while (gnt1_n < 0 && n < 40) begin
      if (bus.done0 && done0_n < 0) done0_n = n;
      if (bus.gnt1) begin
        gnt1_n = n;
        set_req(1, 1'b0, 1'b0, 0, 32'h0);
      end
      if (gnt1_n < 0) begin
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if (!g || done0_n < 0 || gnt1_n != done0_n + 2) begin
      failures++;
      $display("FAIL late_req gnt0=%b done0_at=%0d gnt1_at=%0d required gnt1 two cycles after done0",
               g, done0_n, gnt1_n);
    end
    if (gnt1_n < 0) set_req(1, 1'b0, 1'b0, 0, 32'h0);
    wait_sb_empty("late_req");
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int en_cnt, bad;
    bit ok, g, saw_done;
    // Leave port 0 as the last served port before the reset.
    single_access(0, 1'b0, 3, 32'h0, en_cnt, bad, ok);
    checks++;
    if (!ok || bus.rdata0 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL prep_read0 done=%b rdata0=%h required 1 deadbeef", ok, bus.rdata0);
    end
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 3, 32'h0);
    wait_gnt(0, g);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_enable, bus.mem_readwrite, bus.busy} !== 7'b0 ||
        bus.rdata0 !== '0 || bus.rdata1 !== '0 || bus.mem_ina !== '0) begin
      failures++;
      $display("FAIL async_reset ctl=%b rdata0=%h rdata1=%h ina=%h required all zero",
               {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_enable, bus.mem_readwrite, bus.busy},
               bus.rdata0, bus.rdata1, bus.mem_ina);
    end
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    set_req(1, 1'b1, 1'b0, 5, 32'h0);
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      saw_done = saw_done | bus.done0 | bus.done1;
    end
    rst = 1'b0;
    push_exp(0, 1'b0, 3, 32'h0);
    wait_gnt(0, g);
    checks++;
    if (!g || bus.gnt1 !== 1'b0 || saw_done) begin
      failures++;
      $display("FAIL reset_then_grant gnt0=%b gnt1=%b done_in_reset=%b required 1 0 0", g, bus.gnt1, saw_done);
    end
    set_req(0, 1'b0, 1'b0, 0, 32'h0);
    set_req(1, 1'b0, 1'b0, 0, 32'h0);
    wait_sb_empty("reset_mid");
    @(negedge clk);
  endtask

  task automatic test_latency1();
    int en_cnt, gnt_n, done_n;
    @(posedge clk); #1;
    bus1.req0 = 1'b1; bus1.rw0 = 1'b0; bus1.addr0 = 32'd0;
    en_cnt = 0; gnt_n = -1; done_n = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus1.mem_enable) en_cnt++;
      if (bus1.gnt0) begin
        gnt_n = n;
        bus1.req0 = 1'b0;
      end
      if (bus1.done0 && done_n < 0) done_n = n;
    end
    bus1.req0 = 1'b0;
    checks++;
    if (en_cnt != 1 || gnt_n != 1 || done_n != 2) begin
      failures++;
      $display("FAIL lat1_timing en_cycles=%0d gnt_at=%0d done_at=%0d required 1 1 2", en_cnt, gnt_n, done_n);
    end
    checks++;
    if (bus1.rdata0 !== 32'hCAFE0001 || bus1.rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL lat1_rdata rdata0=%h rdata1=%h required cafe0001 0", bus1.rdata0, bus1.rdata1);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_contention();
    test_late_req();
    test_reset_mid();
    test_latency1();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL final_scoreboard outstanding=%0d required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
